// File: rtl/pattern_serializer.sv
// Parallel-to-serial feeder for the 0110 pattern detector: takes WIDTH-bit words over
// valid/ready and shifts them out one bit per clock, with a one-word hold buffer for gapless words.
module pattern_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    output logic             ser_out_o,
    output logic             ser_valid_o,
    output logic             word_done_o,
    output logic             busy_o
);

    localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             word_done_q, word_done_d;
    logic             accept;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign din_ready_o = !hold_full_q && !reset_i;
    assign accept      = din_valid_i && din_ready_o;

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sh_d    = din_i;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q == CntLast) begin
                    // Reload on the last-bit edge so the next word follows without a gap.
                    if (hold_full_q) begin
                        sh_d        = hold_q;
                        hold_full_d = 1'b0;
                        cnt_d       = '0;
                    end else if (accept) begin
                        sh_d  = din_i;
                        cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    sh_d  = shift_word(sh_q);
                    cnt_d = cnt_q + 1'b1;
                    if (accept) begin
                        hold_d      = din_i;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with the bit being shown.
        ser_valid_d = (state_d == StShift);
        ser_out_d   = ser_valid_d ? head_bit(sh_d) : IDLE_BIT;
        word_done_d = ser_valid_d && (cnt_d == CntLast);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
        end
    end

    assign ser_out_o   = ser_out_q;
    assign ser_valid_o = ser_valid_q;
    assign word_done_o = word_done_q;
    assign busy_o      = (state_q == StShift) || hold_full_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer: an 8-bit MSB-first instance and a 4-bit LSB-first one.
module tb_pattern_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid, din_ready, ser_out, ser_valid, word_done, busy;
    logic [3:0] din2;
    logic       din_valid2, din_ready2, ser_out2, ser_valid2, word_done2, busy2;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    pattern_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .din_i       (din),
        .din_valid_i (din_valid),
        .din_ready_o (din_ready),
        .ser_out_o   (ser_out),
        .ser_valid_o (ser_valid),
        .word_done_o (word_done),
        .busy_o      (busy)
    );

    pattern_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut_lsb (
        .clk_i       (clk),
        .reset_i     (reset),
        .din_i       (din2),
        .din_valid_i (din_valid2),
        .din_ready_o (din_ready2),
        .ser_out_o   (ser_out2),
        .ser_valid_o (ser_valid2),
        .word_done_o (word_done2),
        .busy_o      (busy2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; din = '0; din_valid = 1'b0; din2 = '0; din_valid2 = 1'b0;
        tick(); tick();
        n_checks++;
        if (din_ready !== 1'b0) begin
            n_fails++; $display("FAIL reset_ready_held: got %b expected 0", din_ready);
        end
        reset = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (ser_out !== 1'b1) begin
                n_fails++; $display("FAIL idle_ser_out c=%0d: got %b expected 1", i, ser_out);
            end
            n_checks++;
            if (ser_valid !== 1'b0) begin
                n_fails++; $display("FAIL idle_ser_valid c=%0d: got %b expected 0", i, ser_valid);
            end
            n_checks++;
            if (din_ready !== 1'b1) begin
                n_fails++; $display("FAIL idle_din_ready c=%0d: got %b expected 1", i, din_ready);
            end
            n_checks++;
            if (busy !== 1'b0 || word_done !== 1'b0 || ser_valid2 !== 1'b0) begin
                n_fails++;
                $display("FAIL idle_busy c=%0d: got busy=%b wd=%b v2=%b expected 0/0/0",
                         i, busy, word_done, ser_valid2);
            end
            tick();
        end
    endtask

    task automatic test_single_word;
        logic [7:0] w;
        w = 8'h36;
        din = w; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (ser_out !== w[7-i] || ser_valid !== 1'b1) begin
                n_fails++;
                $display("FAIL single_bit i=%0d: got out=%b v=%b expected out=%b v=1",
                         i, ser_out, ser_valid, w[7-i]);
            end
            n_checks++;
            if (word_done !== (i == 7)) begin
                n_fails++;
                $display("FAIL single_word_done i=%0d: got %b expected %b", i, word_done, i == 7);
            end
            tick();
        end
        n_checks++;
        if (ser_out !== 1'b1 || ser_valid !== 1'b0 || word_done !== 1'b0) begin
            n_fails++;
            $display("FAIL single_after: got out=%b v=%b wd=%b expected 1/0/0",
                     ser_out, ser_valid, word_done);
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] stream;
        logic [7:0]  words [3];
        logic        acc, exp_rdy;
        int          idx;
        stream = 24'hF00FAA;
        words  = '{8'hF0, 8'h0F, 8'hAA};
        idx    = 0;
        din = words[0]; din_valid = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            acc = din_valid && din_ready;
            tick();
            if (acc) idx++;
            if (idx >= 3) begin
                din = '0; din_valid = 1'b0;
            end else if (idx == 2 && c < 8) begin
                din = 8'h3C ^ 8'(c);  // wiggle din while blocked; must not be captured
            end else begin
                din = words[idx];
            end
            exp_rdy = !((c >= 2 && c <= 8) || (c >= 10 && c <= 16));
            n_checks++;
            if (ser_valid !== 1'b1 || ser_out !== stream[24-c]) begin
                n_fails++;
                $display("FAIL b2b_bit c=%0d: got out=%b v=%b expected out=%b v=1",
                         c, ser_out, ser_valid, stream[24-c]);
            end
            n_checks++;
            if (din_ready !== exp_rdy) begin
                n_fails++;
                $display("FAIL b2b_ready c=%0d: got %b expected %b", c, din_ready, exp_rdy);
            end
            n_checks++;
            if (word_done !== (c % 8 == 0)) begin
                n_fails++;
                $display("FAIL b2b_word_done c=%0d: got %b expected %b", c, word_done, c % 8 == 0);
            end
        end
        tick();
        n_checks++;
        if (ser_valid !== 1'b0 || ser_out !== 1'b1 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL b2b_after: got v=%b out=%b busy=%b expected 0/1/0",
                     ser_valid, ser_out, busy);
        end
    endtask

    task automatic test_last_bit_accept;
        logic [15:0] stream;
        stream = 16'hC35A;
        din = 8'hC3; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            n_checks++;
            if (ser_valid !== 1'b1 || ser_out !== stream[16-c]) begin
                n_fails++;
                $display("FAIL lastacc_bit c=%0d: got out=%b v=%b expected out=%b v=1",
                         c, ser_out, ser_valid, stream[16-c]);
            end
            n_checks++;
            if (word_done !== (c % 8 == 0) || busy !== 1'b1) begin
                n_fails++;
                $display("FAIL lastacc_flags c=%0d: got wd=%b busy=%b expected wd=%b busy=1",
                         c, word_done, busy, c % 8 == 0);
            end
            if (c == 8) begin
                din = 8'h5A; din_valid = 1'b1;
            end
            if (c == 9) begin
                din_valid = 1'b0;
                n_checks++;
                if (din_ready !== 1'b1) begin
                    n_fails++; $display("FAIL lastacc_no_hold: got ready=%b expected 1", din_ready);
                end
            end
            tick();
        end
        n_checks++;
        if (ser_valid !== 1'b0 || ser_out !== 1'b1) begin
            n_fails++;
            $display("FAIL lastacc_after: got v=%b out=%b expected 0/1", ser_valid, ser_out);
        end
    endtask

    task automatic test_reset_mid_word;
        logic [7:0] w;
        din = 8'h55; din_valid = 1'b1;
        tick();
        din = 8'hFF;
        tick();
        din_valid = 1'b0;
        tick(); tick();
        n_checks++;
        if (ser_out !== 1'b1 || busy !== 1'b1 || din_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL midrst_before: got out=%b busy=%b ready=%b expected 1/1/0",
                     ser_out, busy, din_ready);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (ser_out !== 1'b1 || ser_valid !== 1'b0 || busy !== 1'b0 || word_done !== 1'b0) begin
            n_fails++;
            $display("FAIL midrst_cleared: got out=%b v=%b busy=%b wd=%b expected 1/0/0/0",
                     ser_out, ser_valid, busy, word_done);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (ser_valid !== 1'b0 || ser_out !== 1'b1 || din_ready !== 1'b1) begin
                n_fails++;
                $display("FAIL midrst_no_resume i=%0d: got v=%b out=%b ready=%b expected 0/1/1",
                         i, ser_valid, ser_out, din_ready);
            end
        end
        w = 8'h0C;
        din = w; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (ser_out !== w[7-i] || ser_valid !== 1'b1 || word_done !== (i == 7)) begin
                n_fails++;
                $display("FAIL midrst_fresh i=%0d: got out=%b v=%b wd=%b expected out=%b v=1 wd=%b",
                         i, ser_out, ser_valid, word_done, w[7-i], i == 7);
            end
            tick();
        end
    endtask

    task automatic test_lsb_first;
        logic [3:0] w;
        w = 4'b0001;
        din2 = w; din_valid2 = 1'b1;
        tick();
        din_valid2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ser_out2 !== w[i] || ser_valid2 !== 1'b1 || word_done2 !== (i == 3)) begin
                n_fails++;
                $display("FAIL lsb_bit i=%0d: got out=%b v=%b wd=%b expected out=%b v=1 wd=%b",
                         i, ser_out2, ser_valid2, word_done2, w[i], i == 3);
            end
            tick();
        end
        n_checks++;
        if (ser_out2 !== 1'b1 || ser_valid2 !== 1'b0 || busy2 !== 1'b0) begin
            n_fails++;
            $display("FAIL lsb_after: got out=%b v=%b busy=%b expected 1/0/0",
                     ser_out2, ser_valid2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_last_bit_accept();
        test_reset_mid_word();
        test_lsb_first();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
- Upstream feeder for the serial 0110 pattern detector.
- Accepts parallel WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on ser_out, which drives the detector's serial input.
- A one-word holding buffer allows back-to-back words with no idle bit between them.
- Between words the line rests at IDLE_BIT so that idle time cannot fabricate pattern bits.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- MSB_FIRST, 1, 1 = shift din[WIDTH-1] first; 0 = shift din[0] first.
- IDLE_BIT, 1, level driven on ser_out when no word is shifting.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- din  in  WIDTH  parallel word to serialize.
- din_valid  in  1  din holds a word.
- din_ready  out  1  block can take a word this cycle; = !hold_full && !reset.
- ser_out  out  1  registered serial bit; feeds the detector's serial input.
- ser_valid  out  1  registered; 1 while ser_out carries a data bit.
- word_done  out  1  registered; 1 during the cycle the last bit of a word is on ser_out.
- busy  out  1  1 when state==SHIFT or hold_full.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. While reset is high at a posedge:
  - state=IDLE, hold_full=0, bit counter=0.
  - ser_out=IDLE_BIT, ser_valid=0, word_done=0, busy=0.
  - din_ready is held 0, so no word is accepted.
- Accept: at a posedge where din_valid && din_ready. din is captured only on accept.
- Internal state: shift register sh[WIDTH], hold register plus hold_full flag, bit counter cnt (0..WIDTH-1, width $clog2(WIDTH)).
- State IDLE:
  - ser_out=IDLE_BIT, ser_valid=0.
  - On accept: sh<=din, cnt<=0, state<=SHIFT. The hold buffer is not used.
  - Latency: the first bit is on ser_out in the cycle after the accepting edge.
- State SHIFT:
  - Each cycle ser_out presents the current bit (sh MSB if MSB_FIRST, else LSB), ser_valid=1.
  - Each edge: sh shifts toward the output end, cnt++.
  - An accept during SHIFT writes hold<=din, hold_full<=1. din_ready then drops next cycle.
- Last-bit edge (cnt==WIDTH-1; word_done=1 in that bit's cycle):
  - If hold_full: sh<=hold, hold_full<=0, cnt<=0, stay in SHIFT. No gap: the new word's first bit follows the old word's last bit on the next cycle.
  - Else if accept on the same edge: sh<=din directly, cnt<=0, stay in SHIFT. No gap.
  - Else: state<=IDLE; ser_out returns to IDLE_BIT next cycle.
- Simultaneous hold_full and accept cannot occur, because din_ready = !hold_full.
- Throughput: one word per WIDTH cycles sustained; ser_valid stays continuously high under a continuous supply of words.
- ser_out, ser_valid and word_done are all driven from registers, with no combinational path from din.
- Reset mid-word: the partial word and the held word are discarded. ser_out=IDLE_BIT from the cycle after the reset edge. No partial bits resume after reset deasserts.
- din changes while din_valid is high and din_ready is low are ignored; the word is taken only on the accepting edge.

Test Plan:
1. Reset, then idle for 5 cycles -> ser_out=1, ser_valid=0, din_ready=1, busy=0 throughout.
2. MSB_FIRST=1, accept 8'h36 at edge k -> ser_out over cycles k+1..k+8 is 0,0,1,1,0,1,1,0; ser_valid=1 for exactly those 8 cycles; word_done=1 only at k+8; ser_out=1 at k+9. The attached detector flags 0110 on the final bit.
3. Back-to-back: accept 8'hF0, then 8'h0F on the next cycle, with din_valid held high and a third word 8'hAA pending -> 16 contiguous valid bits 11110000 00001111; din_ready=0 while 8'h0F sits in hold; 8'hAA is accepted only after hold drains and follows with no gap (24 contiguous bits).
4. Accept on the last-bit edge with hold empty -> the next word's first bit immediately follows; ser_valid never drops.
5. Assert reset on the 4th bit of 8'h55 with a word held -> next cycle ser_out=1, ser_valid=0, busy=0. After deassertion, a fresh 8'h0C shifts correctly as 00001100.
6. MSB_FIRST=0, WIDTH=4, accept 4'b0001 -> ser_out 1,0,0,0, with word_done on the 4th bit.
